// File: rtl/maxnet_feeder.sv
// Input stage for the 4-input MaxNet core: buffers four operands, pulses start,
// waits for the core's done edge (with timeout), and streams the max result out.
module maxnet_feeder #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             nn_start,
  output logic [WIDTH-1:0] nn_inp1,
  output logic [WIDTH-1:0] nn_inp2,
  output logic [WIDTH-1:0] nn_inp3,
  output logic [WIDTH-1:0] nn_inp4,
  input  logic [WIDTH-1:0] nn_max,
  input  logic             nn_done,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [1:0]       state_dbg
);

  // Handshakes: a word (or result) transfers on a rising clk edge where
  // valid and ready are both high; valid must not depend on ready.

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  cnt;
  logic [15:0] wcnt;
  logic        done_q;
  logic        accept;
  logic        done_rise;
  logic        wait_expired;

  assign in_ready     = (state == S_LOAD) & rst;
  assign accept       = in_valid & in_ready;
  assign done_rise    = nn_done & ~done_q;
  assign wait_expired = (wcnt == WCNT_LAST);
  assign nn_start     = (state == S_FIRE);
  assign busy         = (state != S_LOAD);
  assign state_dbg    = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD: if (accept && cnt == 2'd3) state_nx = S_FIRE;
      S_FIRE: state_nx = S_WAIT;
      // A done edge on the terminal wait cycle still counts as completion.
      S_WAIT: begin
        if (done_rise)         state_nx = S_OUT;
        else if (wait_expired) state_nx = S_LOAD;
      end
      S_OUT:  if (res_ready) state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_LOAD;
      cnt         <= 2'd0;
      wcnt        <= 16'd0;
      done_q      <= 1'b0;
      nn_inp1     <= '0;
      nn_inp2     <= '0;
      nn_inp3     <= '0;
      nn_inp4     <= '0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= nn_done;

      if (accept) begin
        case (cnt)
          2'd0: nn_inp1 <= in_data;
          2'd1: nn_inp2 <= in_data;
          2'd2: nn_inp3 <= in_data;
          2'd3: nn_inp4 <= in_data;
          default: ;
        endcase
        cnt <= cnt + 2'd1;
        if (cnt == 2'd0) timeout_err <= 1'b0;
      end

      if (state == S_FIRE)      wcnt <= 16'd0;
      else if (state == S_WAIT) wcnt <= wcnt + 16'd1;

      // Operands are left untouched on abort so the core's inputs stay stable.
      if (state == S_WAIT) begin
        if (done_rise) begin
          res_data  <= nn_max;
          res_valid <= 1'b1;
        end else if (wait_expired) begin
          timeout_err <= 1'b1;
        end
      end

      if (state == S_OUT && res_ready) res_valid <= 1'b0;
    end
  end

endmodule
